// File: rtl/rs_issue_scheduler_if.sv
// Dispatch, writeback-broadcast and issue signals of the reservation-station scheduler,
// plus the package holding the dispatch packet type shared by both sides.
package rs_issue_scheduler_pkg;
    localparam int PREG_W = 6;

    typedef struct packed {
        logic [7:0]        opcode;
        logic [5:0]        rob_idx;
        logic [PREG_W-1:0] dst_preg;
        logic [PREG_W-1:0] src1_preg;
        logic [PREG_W-1:0] src2_preg;
    } disp_packet_t;
endpackage

interface rs_issue_scheduler_if #(
    parameter int RS_ENTRIES = 4,
    parameter int NUM_FUS    = 4,
    parameter int NUM_PREGS  = 64
);
    localparam int PW = $clog2(NUM_PREGS);
    localparam int IW = $clog2(RS_ENTRIES);
    localparam int CW = $clog2(RS_ENTRIES + 1);

    logic                                flush;
    logic                                disp_valid;
    logic                                disp_ready;
    rs_issue_scheduler_pkg::disp_packet_t disp_pkt;
    logic                                disp_s1_rdy;
    logic                                disp_s2_rdy;
    logic [NUM_FUS-1:0]                  wb_valid;
    logic [NUM_FUS*PW-1:0]               wb_preg;
    logic                                iss_valid;
    logic                                iss_ready;
    rs_issue_scheduler_pkg::disp_packet_t iss_pkt;
    logic [IW-1:0]                       iss_idx;
    logic [CW-1:0]                       rs_count;

    // The master is the dispatch/writeback/issue environment; the slave is the scheduler.
    modport master (
        output flush, disp_valid, disp_pkt, disp_s1_rdy, disp_s2_rdy,
        output wb_valid, wb_preg, iss_ready,
        input  disp_ready, iss_valid, iss_pkt, iss_idx, rs_count
    );

    modport slave (
        input  flush, disp_valid, disp_pkt, disp_s1_rdy, disp_s2_rdy,
        input  wb_valid, wb_preg, iss_ready,
        output disp_ready, iss_valid, iss_pkt, iss_idx, rs_count
    );
endinterface

// File: rtl/rs_issue_scheduler.sv
// Reservation-station scheduler: tag wakeup from FU broadcasts, one issue per cycle.
// Define RS_AGE_SELECT_EN for oldest-first select via an age matrix; default is lowest index.
module rs_issue_scheduler
    import rs_issue_scheduler_pkg::*;
#(
    parameter int RS_ENTRIES = 4,
    parameter int NUM_FUS    = 4,
    parameter int NUM_PREGS  = 64
) (
    input logic                 clk,
    input logic                 rst,
    rs_issue_scheduler_if.slave bus
);
    localparam int PW = $clog2(NUM_PREGS);
    localparam int IW = $clog2(RS_ENTRIES);
    localparam int CW = $clog2(RS_ENTRIES + 1);
    localparam logic [CW-1:0] FULL = CW'(RS_ENTRIES);

    logic [RS_ENTRIES-1:0] valid;
    logic [RS_ENTRIES-1:0] s1_rdy;
    logic [RS_ENTRIES-1:0] s2_rdy;
    disp_packet_t          pkt [RS_ENTRIES];
    logic [CW-1:0]         count;

    logic [NUM_FUS-1:0]    wb_v;
    logic [NUM_FUS*PW-1:0] wb_p;
    logic [RS_ENTRIES-1:0] wake1;
    logic [RS_ENTRIES-1:0] wake2;
    logic [RS_ENTRIES-1:0] cand;
    logic [IW-1:0]         free_idx;
    logic [IW-1:0]         sel_idx;
    logic                  disp_fire;
    logic                  iss_fire;
    logic                  new_s1;
    logic                  new_s2;

    function automatic logic tag_hit(input logic [PW-1:0]         tag,
                                     input logic [NUM_FUS-1:0]    wv,
                                     input logic [NUM_FUS*PW-1:0] wp);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_FUS; i++) begin
            hit |= wv[i] && (wp[i*PW +: PW] == tag);
        end
        return hit;
    endfunction

    assign wb_v = bus.wb_valid;
    assign wb_p = bus.wb_preg;

    always_comb begin
        for (int e = 0; e < RS_ENTRIES; e++) begin
            wake1[e] = tag_hit(pkt[e].src1_preg, wb_v, wb_p);
            wake2[e] = tag_hit(pkt[e].src2_preg, wb_v, wb_p);
            cand[e]  = valid[e] && s1_rdy[e] && s2_rdy[e];
        end
    end

    // Free slot comes from registered valid bits, so a slot issued this cycle is not reused yet.
    always_comb begin
        free_idx = '0;
        for (int e = RS_ENTRIES - 1; e >= 0; e--) begin
            if (!valid[e]) free_idx = IW'(e);
        end
    end

    assign new_s1 = bus.disp_s1_rdy || (bus.disp_pkt.src1_preg == '0) ||
                    tag_hit(bus.disp_pkt.src1_preg, wb_v, wb_p);
    assign new_s2 = bus.disp_s2_rdy || (bus.disp_pkt.src2_preg == '0) ||
                    tag_hit(bus.disp_pkt.src2_preg, wb_v, wb_p);

`ifdef RS_AGE_SELECT_EN
    // age[i][j] set means entry i was dispatched before entry j.
    logic [RS_ENTRIES-1:0] age      [RS_ENTRIES];
    logic [RS_ENTRIES-1:0] age_next [RS_ENTRIES];
    logic                  blocked;

    always_comb begin
        sel_idx = '0;
        blocked = 1'b0;
        for (int e = RS_ENTRIES - 1; e >= 0; e--) begin
            blocked = 1'b0;
            for (int j = 0; j < RS_ENTRIES; j++) begin
                if (cand[j] && age[j][e]) blocked = 1'b1;
            end
            if (cand[e] && !blocked) sel_idx = IW'(e);
        end
    end

    always_comb begin
        for (int i = 0; i < RS_ENTRIES; i++) age_next[i] = age[i];
        if (iss_fire) begin
            for (int i = 0; i < RS_ENTRIES; i++) age_next[i][sel_idx] = 1'b0;
            age_next[sel_idx] = '0;
        end
        if (disp_fire) begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                age_next[i][free_idx] = valid[i] && !(iss_fire && (sel_idx == IW'(i)));
            end
            age_next[free_idx] = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RS_ENTRIES; i++) age[i] <= '0;
        end else if (bus.flush) begin
            for (int i = 0; i < RS_ENTRIES; i++) age[i] <= '0;
        end else begin
            for (int i = 0; i < RS_ENTRIES; i++) age[i] <= age_next[i];
        end
    end
`else
    always_comb begin
        sel_idx = '0;
        for (int e = RS_ENTRIES - 1; e >= 0; e--) begin
            if (cand[e]) sel_idx = IW'(e);
        end
    end
`endif

    assign disp_fire      = bus.disp_valid && bus.disp_ready;
    assign iss_fire       = bus.iss_valid && bus.iss_ready;
    assign bus.disp_ready = (count < FULL);
    assign bus.iss_valid  = |cand;
    assign bus.iss_idx    = sel_idx;
    assign bus.iss_pkt    = bus.iss_valid ? pkt[sel_idx] : '0;
    assign bus.rs_count   = count;

    // Flush wins over dispatch and issue; the issue handshake still happens on the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid  <= '0;
            s1_rdy <= '0;
            s2_rdy <= '0;
            count  <= '0;
            for (int e = 0; e < RS_ENTRIES; e++) pkt[e] <= '0;
        end else if (bus.flush) begin
            valid  <= '0;
            s1_rdy <= '0;
            s2_rdy <= '0;
            count  <= '0;
        end else begin
            for (int e = 0; e < RS_ENTRIES; e++) begin
                if (valid[e]) begin
                    s1_rdy[e] <= s1_rdy[e] | wake1[e];
                    s2_rdy[e] <= s2_rdy[e] | wake2[e];
                end
            end
            if (iss_fire) begin
                valid[sel_idx]  <= 1'b0;
                s1_rdy[sel_idx] <= 1'b0;
                s2_rdy[sel_idx] <= 1'b0;
            end
            if (disp_fire) begin
                valid[free_idx]  <= 1'b1;
                pkt[free_idx]    <= bus.disp_pkt;
                s1_rdy[free_idx] <= new_s1;
                s2_rdy[free_idx] <= new_s2;
            end
            count <= count + CW'(disp_fire) - CW'(iss_fire);
        end
    end
endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Self-checking bench for rs_issue_scheduler: directed scenarios then random traffic
// compared against a slot-array reference model (oldest-first when RS_AGE_SELECT_EN).
module tb_rs_issue_scheduler;
    import rs_issue_scheduler_pkg::*;

    localparam int RS = 4;
    localparam int NF = 4;
    localparam int NP = 64;
    localparam int PW = $clog2(NP);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rs_issue_scheduler_if #(.RS_ENTRIES(RS), .NUM_FUS(NF), .NUM_PREGS(NP)) bus ();

    rs_issue_scheduler #(.RS_ENTRIES(RS), .NUM_FUS(NF), .NUM_PREGS(NP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit           v;
        disp_packet_t p;
        bit           r1;
        bit           r2;
        int unsigned  seq;
    } ment_t;

    ment_t       m [RS];
    int unsigned seq_ctr = 0;

    task automatic check_val(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic int model_count();
        int n = 0;
        foreach (m[e]) if (m[e].v) n++;
        return n;
    endfunction

    // Returns -1 when no entry has both sources ready.
    function automatic int model_select();
        int best = -1;
        foreach (m[e]) begin
            if (m[e].v && m[e].r1 && m[e].r2) begin
`ifdef RS_AGE_SELECT_EN
                if (best < 0 || m[e].seq < m[best].seq) best = e;
`else
                if (best < 0) best = e;
`endif
            end
        end
        return best;
    endfunction

    function automatic bit wb_hit(input logic [PW-1:0] tag);
        for (int f = 0; f < NF; f++) begin
            if (bus.wb_valid[f] && bus.wb_preg[f*PW +: PW] == tag) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void model_clear();
        foreach (m[e]) m[e].v = 1'b0;
    endfunction

    function automatic disp_packet_t mk_pkt(input int dst, input int s1, input int s2);
        disp_packet_t p = '0;
        p.dst_preg  = PW'(dst);
        p.src1_preg = PW'(s1);
        p.src2_preg = PW'(s2);
        return p;
    endfunction

    function automatic logic [NF*PW-1:0] wb_one(input int fu, input int tag);
        logic [NF*PW-1:0] w = '0;
        w[fu*PW +: PW] = PW'(tag);
        return w;
    endfunction

    task automatic applyStimulus(input bit dv, input disp_packet_t p, input bit r1, input bit r2,
                                 input bit ir, input logic [NF-1:0] wv,
                                 input logic [NF*PW-1:0] wp, input bit fl);
        bus.disp_valid  = dv;
        bus.disp_pkt    = p;
        bus.disp_s1_rdy = r1;
        bus.disp_s2_rdy = r2;
        bus.iss_ready   = ir;
        bus.wb_valid    = wv;
        bus.wb_preg     = wp;
        bus.flush       = fl;
    endtask

    task automatic idle(input bit ir);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, ir, '0, '0, 1'b0);
    endtask

    task automatic checkOutput();
        int sel;
        disp_packet_t exp_pkt;
        sel = model_select();
        exp_pkt = '0;
        if (sel >= 0) exp_pkt = m[sel].p;
        check_val("rs_count", bus.rs_count, model_count());
        check_val("disp_ready", bus.disp_ready, model_count() < RS);
        check_val("iss_valid", bus.iss_valid, sel >= 0);
        check_val("iss_pkt", bus.iss_pkt, exp_pkt);
        if (sel >= 0) check_val("iss_idx", bus.iss_idx, sel);
    endtask

    // Compare at the falling edge, then advance the model by the rules for the coming edge.
    task automatic step();
        int sel;
        int free_slot;
        bit dfire;
        bit ifire;
        @(negedge clk);
        checkOutput();
        sel       = model_select();
        dfire     = bus.disp_valid && (model_count() < RS);
        ifire     = (sel >= 0) && bus.iss_ready;
        free_slot = -1;
        for (int e = RS - 1; e >= 0; e--) if (!m[e].v) free_slot = e;
        if (bus.flush) begin
            model_clear();
        end else begin
            foreach (m[e]) begin
                if (m[e].v) begin
                    m[e].r1 |= wb_hit(m[e].p.src1_preg);
                    m[e].r2 |= wb_hit(m[e].p.src2_preg);
                end
            end
            if (ifire) m[sel].v = 1'b0;
            if (dfire) begin
                m[free_slot].v   = 1'b1;
                m[free_slot].p   = bus.disp_pkt;
                m[free_slot].r1  = bus.disp_s1_rdy || (bus.disp_pkt.src1_preg == 0) ||
                                   wb_hit(bus.disp_pkt.src1_preg);
                m[free_slot].r2  = bus.disp_s2_rdy || (bus.disp_pkt.src2_preg == 0) ||
                                   wb_hit(bus.disp_pkt.src2_preg);
                m[free_slot].seq = seq_ctr;
                seq_ctr++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle(1'b1);
        repeat (6) step();
    endtask

    initial begin
        disp_packet_t     rp;
        logic [NF-1:0]    rwv;
        logic [NF*PW-1:0] rwp;

        model_clear();
        idle(1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_disp_ready", bus.disp_ready, 1'b1);
        check_val("reset_iss_valid", bus.iss_valid, 1'b0);
        check_val("reset_iss_pkt", bus.iss_pkt, '0);
        check_val("reset_iss_idx", bus.iss_idx, 0);
        check_val("reset_rs_count", bus.rs_count, 0);
        rst = 1'b0;

        $display("[TB] basic dispatch to issue");
        applyStimulus(1'b1, mk_pkt(5, 1, 2), 1'b1, 1'b1, 1'b1, '0, '0, 1'b0);
        step();
        idle(1'b1);
        check_val("t1_iss_valid", bus.iss_valid, 1'b1);
        check_val("t1_dst", bus.iss_pkt.dst_preg, 5);
        check_val("t1_idx", bus.iss_idx, 0);
        step();
        check_val("t1_count_after", bus.rs_count, 0);

        $display("[TB] wakeup via writeback broadcast");
        applyStimulus(1'b1, mk_pkt(11, 7, 0), 1'b0, 1'b0, 1'b1, '0, '0, 1'b0);
        step();
        idle(1'b1);
        check_val("t2_waiting", bus.iss_valid, 1'b0);
        step();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 4'b0100, wb_one(2, 7), 1'b0);
        check_val("t2_not_yet", bus.iss_valid, 1'b0);
        step();
        idle(1'b1);
        check_val("t2_woken", bus.iss_valid, 1'b1);
        check_val("t2_dst", bus.iss_pkt.dst_preg, 11);
        step();

        $display("[TB] dispatch-cycle bypass wakeup");
        applyStimulus(1'b1, mk_pkt(12, 0, 9), 1'b1, 1'b0, 1'b1, 4'b0001, wb_one(0, 9), 1'b0);
        step();
        idle(1'b1);
        check_val("t3_bypass", bus.iss_valid, 1'b1);
        check_val("t3_dst", bus.iss_pkt.dst_preg, 12);
        step();

        $display("[TB] full station backpressure");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, mk_pkt(21 + k, 0, 0), 1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
            step();
        end
        check_val("t4_full_ready", bus.disp_ready, 1'b0);
        check_val("t4_full_count", bus.rs_count, 4);
        applyStimulus(1'b1, mk_pkt(25, 0, 0), 1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
        step();
        check_val("t4_fifth_rejected", bus.rs_count, 4);
        idle(1'b1);
        #1;
        check_val("t4_no_comb_ready", bus.disp_ready, 1'b0);
        step();
        idle(1'b0);
        check_val("t4_ready_next", bus.disp_ready, 1'b1);
        check_val("t4_count_next", bus.rs_count, 3);
        drain();

        $display("[TB] older entry wakes late");
        applyStimulus(1'b1, mk_pkt(3, 20, 0), 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
        step();
        applyStimulus(1'b1, mk_pkt(4, 0, 0), 1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
        step();
        check_val("t5_only_ready", bus.iss_pkt.dst_preg, 4);
        check_val("t5_only_idx", bus.iss_idx, 1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'b0010, wb_one(1, 20), 1'b0);
        step();
        idle(1'b1);
        check_val("t5_first", bus.iss_pkt.dst_preg, 3);
        step();
        check_val("t5_second", bus.iss_pkt.dst_preg, 4);
        drain();

        $display("[TB] flush with simultaneous dispatch");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, mk_pkt(40 + k, 0, 0), 1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
            step();
        end
        applyStimulus(1'b1, mk_pkt(30, 0, 0), 1'b1, 1'b1, 1'b1, '0, '0, 1'b1);
        step();
        idle(1'b1);
        check_val("t6_count", bus.rs_count, 0);
        check_val("t6_iss_valid", bus.iss_valid, 1'b0);
        check_val("t6_disp_ready", bus.disp_ready, 1'b1);
        step();
        check_val("t6_pkt_absent", bus.iss_valid, 1'b0);

        $display("[TB] asynchronous reset mid-operation");
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, mk_pkt(50 + k, 0, 0), 1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
            step();
        end
        idle(1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_count", bus.rs_count, 0);
        check_val("arst_iss_valid", bus.iss_valid, 1'b0);
        check_val("arst_iss_pkt", bus.iss_pkt, '0);
        check_val("arst_disp_ready", bus.disp_ready, 1'b1);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            rp           = '0;
            rp.opcode    = 8'($urandom);
            rp.rob_idx   = 6'($urandom);
            rp.dst_preg  = PW'($urandom);
            rp.src1_preg = PW'($urandom_range(0, 15));
            rp.src2_preg = PW'($urandom_range(0, 15));
            rwv = '0;
            rwp = '0;
            for (int f = 0; f < NF; f++) begin
                rwv[f]          = ($urandom_range(0, 3) == 0);
                rwp[f*PW +: PW] = PW'($urandom_range(0, 15));
            end
            applyStimulus($urandom_range(0, 9) < 6, rp,
                          $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
                          $urandom_range(0, 9) < 7, rwv, rwp,
                          $urandom_range(0, 49) == 0);
            step();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
